// File: rtl/seg7_scan.sv
// Six-digit multiplexed 7-segment driver with a per-slot anti-ghost blank gap and per-frame snapshot.
// Optional leading-zero blanking on hours tens when SEG7_SCAN_LZB_EN is defined.
module seg7_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16,
  parameter bit ACT_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit_s1,
  input  logic [3:0] digit_s10,
  input  logic [3:0] digit_m1,
  input  logic [3:0] digit_m10,
  input  logic [3:0] digit_h1,
  input  logic [3:0] digit_h10,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       frame_start
);

  localparam int              CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [5:0]      AN_OFF    = {6{ACT_LOW}};
  localparam logic [6:0]      SEG_OFF   = {7{ACT_LOW}};

  typedef enum logic {
    PH_BLANK,
    PH_DRIVE
  } phase_e;

  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [3:0]       shadow_q [6];
  logic [6:0]       seg_q, seg_d;
  logic [5:0]       an_q, an_d;
  logic             frame_start_q;
  logic             snap;
  phase_e           phase;
  logic [3:0]       digit_sel;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0:    r = 7'h3F;
      4'd1:    r = 7'h06;
      4'd2:    r = 7'h5B;
      4'd3:    r = 7'h4F;
      4'd4:    r = 7'h66;
      4'd5:    r = 7'h6D;
      4'd6:    r = 7'h7D;
      4'd7:    r = 7'h07;
      4'd8:    r = 7'h7F;
      4'd9:    r = 7'h6F;
      default: r = 7'h00;
    endcase
    return r;
  endfunction

  always_comb begin
    slot_cnt_d = slot_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (slot_cnt_q == CNT_LAST) begin
      slot_cnt_d = '0;
      idx_d      = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
  end

  // The snapshot only ever loads during a blank cycle, so the DRIVE portion of slot 0 already sees it.
  always_comb begin
    snap  = (slot_cnt_q == '0) && (idx_q == 3'd0);
    phase = (slot_cnt_q < BLANK_END) ? PH_BLANK : PH_DRIVE;
  end

  always_comb begin
    case (idx_q)
      3'd0:    digit_sel = shadow_q[0];
      3'd1:    digit_sel = shadow_q[1];
      3'd2:    digit_sel = shadow_q[2];
      3'd3:    digit_sel = shadow_q[3];
      3'd4:    digit_sel = shadow_q[4];
      3'd5:    digit_sel = shadow_q[5];
      default: digit_sel = 4'd0;
    endcase
  end

  always_comb begin
    an_d  = AN_OFF;
    seg_d = SEG_OFF;
    if (phase == PH_DRIVE) begin
      an_d  = (6'd1 << idx_q) ^ AN_OFF;
      seg_d = dec7(digit_sel) ^ SEG_OFF;
    end
`ifdef SEG7_SCAN_LZB_EN
    if ((idx_q == 3'd5) && (shadow_q[5] == 4'd0)) begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_q    <= '0;
      idx_q         <= 3'd0;
      for (int i = 0; i < 6; i++) shadow_q[i] <= 4'd0;
      an_q          <= AN_OFF;
      seg_q         <= SEG_OFF;
      frame_start_q <= 1'b0;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      idx_q         <= idx_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      frame_start_q <= snap;
      if (snap) begin
        shadow_q[0] <= digit_s1;
        shadow_q[1] <= digit_s10;
        shadow_q[2] <= digit_m1;
        shadow_q[3] <= digit_m10;
        shadow_q[4] <= digit_h1;
        shadow_q[5] <= digit_h10;
      end
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: an active-low and an active-high instance share stimulus
// and are compared each cycle against a cycle model of the scan/snapshot behaviour.
module tb_seg7_scan;

  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;
  localparam logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       fs;
  } expected_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] digitS1, digitS10, digitM1, digitM10, digitH1, digitH10;
  logic [6:0] segLow, segHigh;
  logic [5:0] anLow, anHigh;
  logic       fsLow, fsHigh;

  expected_t  sb [$];
  int         compared = 0;
  int         mismatched = 0;
  int         mSlot, mIdx;
  logic [3:0] mShadow [6];

  always #5 clock = ~clock;

  seg7_scan #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .ACT_LOW(1'b1)) dutLow (
    .clk(clock), .rst(reset),
    .digit_s1(digitS1), .digit_s10(digitS10), .digit_m1(digitM1),
    .digit_m10(digitM10), .digit_h1(digitH1), .digit_h10(digitH10),
    .seg(segLow), .an(anLow), .frame_start(fsLow)
  );

  seg7_scan #(.SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .ACT_LOW(1'b0)) dutHigh (
    .clk(clock), .rst(reset),
    .digit_s1(digitS1), .digit_s10(digitS10), .digit_m1(digitM1),
    .digit_m10(digitM10), .digit_h1(digitH1), .digit_h10(digitH10),
    .seg(segHigh), .an(anHigh), .frame_start(fsHigh)
  );

  // Model state mirrors what the display should be doing after reset release.
  task automatic resetModel();
    mSlot = 0;
    mIdx  = 0;
    for (int i = 0; i < 6; i++) mShadow[i] = 4'd0;
    sb.delete();
  endtask

  // Outputs while reset is asserted: everything off, no frame pulse.
  task automatic checkResetState(input string tag);
    compared++;
    assert (anLow === 6'h3F) else begin mismatched++; $error("FAIL %s anLow got %h want 3f", tag, anLow); end
    compared++;
    assert (segLow === 7'h7F) else begin mismatched++; $error("FAIL %s segLow got %h want 7f", tag, segLow); end
    compared++;
    assert (fsLow === 1'b0) else begin mismatched++; $error("FAIL %s fsLow got %b want 0", tag, fsLow); end
    compared++;
    assert (anHigh === 6'h00) else begin mismatched++; $error("FAIL %s anHigh got %h want 00", tag, anHigh); end
    compared++;
    assert (segHigh === 7'h00) else begin mismatched++; $error("FAIL %s segHigh got %h want 00", tag, segHigh); end
  endtask

  task automatic checkOutput(input string tag);
    expected_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL %s scoreboard empty got an=%h want an=entry", tag, anLow);
    end else begin
      e = sb.pop_front();
      compared++;
      assert (anLow === e.an) else begin mismatched++; $error("FAIL %s anLow got %h want %h (slot %0d idx %0d)", tag, anLow, e.an, mSlot, mIdx); end
      compared++;
      assert (segLow === e.seg) else begin mismatched++; $error("FAIL %s segLow got %h want %h (slot %0d idx %0d)", tag, segLow, e.seg, mSlot, mIdx); end
      compared++;
      assert (fsLow === e.fs) else begin mismatched++; $error("FAIL %s fsLow got %b want %b (slot %0d idx %0d)", tag, fsLow, e.fs, mSlot, mIdx); end
      compared++;
      assert (anHigh === ~e.an) else begin mismatched++; $error("FAIL %s anHigh got %h want %h", tag, anHigh, ~e.an); end
      compared++;
      assert (segHigh === ~e.seg) else begin mismatched++; $error("FAIL %s segHigh got %h want %h", tag, segHigh, ~e.seg); end
      compared++;
      assert (fsHigh === e.fs) else begin mismatched++; $error("FAIL %s fsHigh got %b want %b", tag, fsHigh, e.fs); end
      compared++;
      assert ($countones(~anLow) <= 1) else begin mismatched++; $error("FAIL %s oneHot anLow got %h want at most one low", tag, anLow); end
    end
  endtask

  // Each cycle: predict the post-edge outputs, push them, clock, advance the model, then compare.
  task automatic applyStimulus(input int cycles, input string tag);
    expected_t e;
    logic [3:0] d;
    logic       capture;
    for (int c = 0; c < cycles; c++) begin
      d       = mShadow[mIdx];
      capture = (mSlot == 0) && (mIdx == 0);
      e.fs    = capture;
      if (mSlot < BLANK_CYC) begin
        e.an  = 6'h3F;
        e.seg = 7'h7F;
      end else begin
        e.an  = ~(6'd1 << mIdx);
        e.seg = ~DEC[d];
      end
`ifdef SEG7_SCAN_LZB_EN
      if (mIdx == 5 && mShadow[5] == 4'd0) begin
        e.an  = 6'h3F;
        e.seg = 7'h7F;
      end
`endif
      sb.push_back(e);
      @(posedge clock);
      if (capture) begin
        mShadow[0] = digitS1;
        mShadow[1] = digitS10;
        mShadow[2] = digitM1;
        mShadow[3] = digitM10;
        mShadow[4] = digitH1;
        mShadow[5] = digitH10;
      end
      if (mSlot == SCAN_DIV - 1) begin
        mSlot = 0;
        mIdx  = (mIdx == 5) ? 0 : mIdx + 1;
      end else begin
        mSlot++;
      end
      #1;
      checkOutput(tag);
    end
  endtask

  initial begin
    reset    = 1'b1;
    digitS1  = 4'd1;
    digitS10 = 4'd2;
    digitM1  = 4'd3;
    digitM10 = 4'd4;
    digitH1  = 4'd5;
    digitH10 = 4'd0;
    resetModel();
    #2;
    checkResetState("resetInitial");

    @(negedge clock);
    reset = 1'b0;
    $display("[TB] scan order with digits 1,2,3,4,5,0");
    applyStimulus(2 * 6 * SCAN_DIV, "scanOrder");

    $display("[TB] snapshot: s1 9 then 0 mid-frame");
    digitS1 = 4'd9;
    applyStimulus(3 * SCAN_DIV, "snapLoad");
    digitS1 = 4'd0;
    applyStimulus(3 * SCAN_DIV + 6 * SCAN_DIV, "snapHold");

    $display("[TB] decode sweep on m1");
    for (int v = 0; v < 16; v++) begin
      digitM1 = 4'(v);
      applyStimulus(6 * SCAN_DIV, "decodeM1");
    end

    $display("[TB] hours tens nonzero");
    digitH10 = 4'd2;
    applyStimulus(6 * SCAN_DIV, "h10Two");
    digitH10 = 4'd0;
    applyStimulus(6 * SCAN_DIV, "h10Zero");

    $display("[TB] reset asserted mid-drive");
    applyStimulus(5, "preReset");
    #2;
    reset = 1'b1;
    #1;
    checkResetState("resetMidDrive");
    resetModel();
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(6 * SCAN_DIV + 12, "afterReset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
